pe_vec_mac: RTL and testbench
=============================

PE_VEC_MAC -- requirements
Module: pe_vec_mac

Interface
REQ-001 SHALL have parameter LANES, default 4, number of parallel ifmap/weight pairs per beat.
REQ-002 SHALL have parameter ACC_W, default 32, accumulator/bias/opsum width.
REQ-003 SHALL have parameter ZP, default 128, ifmap zero point subtracted per lane.
REQ-004 SHALL have parameter LEN_W, default 16, width of beat-count field.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port start  input  1  begin new dot-product job; sampled only when busy=0.
REQ-008 SHALL have port len  input  LEN_W  beats in the job, captured with start.
REQ-009 SHALL have port bias  input  ACC_W signed  initial accumulator value, captured with start.
REQ-010 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-011 SHALL have port in_valid  input  1  beat offered.
REQ-012 SHALL have port in_ready  output  1  beat accepted when in_valid&in_ready.
REQ-013 SHALL have port ifmap  input  LANES*8  unsigned 8-bit per lane, lane 0 in bits [7:0].
REQ-014 SHALL have port weight  input  LANES*8  signed 8-bit per lane, lane 0 in bits [7:0].
REQ-015 SHALL have port out_valid  output  1  opsum valid.
REQ-016 SHALL have port out_ready  input  1  consumer accepts opsum.
REQ-017 SHALL have port opsum  output  ACC_W signed  final saturated accumulation.
REQ-018 SHALL have port ovf  output  1  sticky saturation flag for current job, valid with out_valid.

Function
REQ-019 SHALL implement FSM states IDLE, ACCUM, DRAIN, OUT.
REQ-020 IDLE: start=1 captures len and bias, loads accumulator with bias, clears ovf and beat counter; next state ACCUM if len!=0, DRAIN if len=0.
REQ-021 in_ready SHALL be 1 only in ACCUM; beats offered in other states are ignored.
REQ-022 Per lane, term = (ifmap - ZP) * weight, 9-bit signed by 8-bit signed into 17-bit signed; lane sum is sign-extended to 17+clog2(LANES) bits, exact, no saturation.
REQ-023 Stage 1: accepted beat's lane sum SHALL be registered at the accepting edge; stage 2: registered sum SHALL be added to accumulator on the following edge.
REQ-024 Accumulator add SHALL saturate to signed ACC_W min/max; any saturation event SHALL set ovf, which stays set until next start.
REQ-025 ACCUM -> DRAIN on the edge accepting beat number len; DRAIN lasts exactly one cycle (stage-2 flush), then OUT.
REQ-026 Latency: last beat accepted at edge T -> out_valid high after edge T+2; len=0 -> out_valid high two edges after start edge, opsum=bias.
REQ-027 OUT: out_valid=1, opsum and ovf SHALL be held stable while out_ready=0; on out_valid&out_ready return to IDLE, out_valid deasserts the next cycle.
REQ-028 start while busy=1 SHALL be ignored, including the cycle of the output handshake.
REQ-029 in_valid gaps during ACCUM SHALL stall counting without affecting the accumulated result.

Reset
REQ-030 rst=1 SHALL asynchronously force IDLE and clear accumulator, pipeline register, beat counter, opsum, ovf, busy, in_ready, out_valid to 0.
REQ-031 rst mid-job SHALL discard the job; no out_valid is produced for it.

Structure
REQ-032 Shared package pe_pkg SHALL hold the FSM state typedef and default parameter constants (LANES, ACC_W, ZP, LEN_W).
REQ-033 Lane multiply and adder tree SHALL be a combinational sub-module pe_lane_dot, instantiated once; FSM, counter, pipeline and saturation stay in pe_vec_mac.

Verification
REQ-034 LANES=4, bias=10, len=1, ifmap all 130, weight all 3 -> opsum=34 (10+4*2*3), ovf=0, out_valid two edges after beat.
REQ-035 len=0, bias=-5 -> opsum=-5, out_valid two edges after start, in_ready never asserted.
REQ-036 len=3, ifmap 0 and weight 127 every lane, bias=0, in_valid toggled 1/0 -> opsum=-195072, exactly 3 beats accepted.
REQ-037 ACC_W=16, bias=32767, len=1, ifmap 255, weight 127 -> opsum=32767, ovf=1; next job with small values -> ovf=0.
REQ-038 out_ready held 0 for 5 cycles with start pulsed -> opsum stable, start ignored, IDLE entered only after handshake.
REQ-039 rst asserted after 2 of 4 beats -> all outputs 0 immediately, no out_valid; following clean job correct.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared types and default sizing for the vector MAC processing element.
package pe_pkg;

  localparam int LANES_D = 4;
  localparam int ACC_W_D = 32;
  localparam int ZP_D    = 128;
  localparam int LEN_W_D = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_t;

  // Exact width of a per-beat lane sum: one 17-bit product per lane plus growth.
  function automatic int sum_w(input int lanes);
    return 17 + $clog2(lanes);
  endfunction

endpackage

// File: rtl/pe_lane_dot.sv
// Combinational per-beat dot product: zero-point-corrected ifmap times weight, summed over lanes.
module pe_lane_dot
  import pe_pkg::*;
#(
  parameter int LANES = LANES_D,
  parameter int ZP    = ZP_D,
  parameter int SUM_W = sum_w(LANES_D)
) (
  input  logic [LANES*8-1:0]       ifmap,
  input  logic [LANES*8-1:0]       weight,
  output logic signed [SUM_W-1:0]  sum
);

  localparam logic signed [8:0] ZP9 = 9'(ZP);

  logic signed [LANES-1:0][16:0] term;

  // One 9x8 signed multiplier per lane; products fit 17 bits exactly.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic signed [8:0]  dx;
    logic signed [16:0] dx_e;
    logic signed [16:0] wt_e;
    assign dx        = $signed({1'b0, ifmap[g*8 +: 8]}) - ZP9;
    assign dx_e      = 17'(dx);
    assign wt_e      = 17'($signed(weight[g*8 +: 8]));
    assign term[g]   = dx_e * wt_e;
  end

  // Reduce lane products at full lane-sum width, so the result is exact.
  always_comb begin
    sum = '0;
    for (int i = 0; i < LANES; i++) begin
      sum = sum + SUM_W'($signed(term[i]));
    end
  end

endmodule

// File: rtl/pe_vec_mac.sv
// Vector MAC processing element: job FSM, beat counter, two-stage accumulate
// pipeline with saturation, and a registered opsum/ovf output held until handshake.
module pe_vec_mac
  import pe_pkg::*;
#(
  parameter int LANES = LANES_D,
  parameter int ACC_W = ACC_W_D,
  parameter int ZP    = ZP_D,
  parameter int LEN_W = LEN_W_D
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [LEN_W-1:0]         len,
  input  logic signed [ACC_W-1:0]  bias,
  output logic                     busy,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*8-1:0]       ifmap,
  input  logic [LANES*8-1:0]       weight,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  opsum,
  output logic                     ovf
);

  localparam int SUM_W = sum_w(LANES);
  localparam int EXT_W = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 1;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t state, state_nx;

  logic [LEN_W-1:0]         len_q;
  logic [LEN_W-1:0]         cnt;
  logic [LEN_W-1:0]         cnt_inc;
  logic signed [SUM_W-1:0]  lane_sum;
  logic signed [SUM_W-1:0]  pipe_q;
  logic                     pipe_v;
  logic signed [ACC_W-1:0]  acc;
  logic                     acc_ovf;
  logic                     accept;
  logic                     start_ok;
  logic signed [EXT_W-1:0]  sum_x;
  logic signed [ACC_W-1:0]  sat_val;
  logic                     sat_hit;

  pe_lane_dot #(
    .LANES (LANES),
    .ZP    (ZP),
    .SUM_W (SUM_W)
  ) u_dot (
    .ifmap  (ifmap),
    .weight (weight),
    .sum    (lane_sum)
  );

  assign in_ready = (state == ACCUM);
  assign busy     = (state != IDLE);
  assign accept   = in_valid & in_ready;
  assign start_ok = (state == IDLE) & start;
  assign cnt_inc  = cnt + LEN_W'(1);

  // Widen before adding so the overflow check sees the true sum.
  always_comb begin
    sum_x   = EXT_W'(acc) + EXT_W'(pipe_q);
    sat_val = acc;
    sat_hit = 1'b0;
    if (sum_x > EXT_W'(ACC_MAX)) begin
      sat_val = ACC_MAX;
      sat_hit = 1'b1;
    end else if (sum_x < EXT_W'(ACC_MIN)) begin
      sat_val = ACC_MIN;
      sat_hit = 1'b1;
    end else begin
      sat_val = sum_x[ACC_W-1:0];
    end
  end

  // Next-state logic; start is only honoured from IDLE.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = (len == '0) ? DRAIN : ACCUM;
      ACCUM:   if (accept && (cnt_inc == len_q)) state_nx = DRAIN;
      DRAIN:   state_nx = OUT;
      OUT:     if (out_valid && out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Job capture, beat counter, stage-1 lane-sum register, stage-2 saturating accumulate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q   <= '0;
      cnt     <= '0;
      pipe_q  <= '0;
      pipe_v  <= 1'b0;
      acc     <= '0;
      acc_ovf <= 1'b0;
    end else begin
      pipe_v <= accept;
      if (accept) begin
        pipe_q <= lane_sum;
        cnt    <= cnt_inc;
      end
      if (start_ok) begin
        len_q   <= len;
        cnt     <= '0;
        acc     <= bias;
        acc_ovf <= 1'b0;
      end else if (pipe_v) begin
        acc <= sat_val;
        if (sat_hit) acc_ovf <= 1'b1;
      end
    end
  end

  // Output register: captured once on entering OUT, then frozen until the handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      opsum     <= '0;
      ovf       <= 1'b0;
    end else begin
      if (start_ok) begin
        ovf <= 1'b0;
      end
      if ((state == OUT) && !out_valid) begin
        out_valid <= 1'b1;
        opsum     <= acc;
        ovf       <= acc_ovf;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pe_vec_mac.sv
// Directed bench for pe_vec_mac: a 32-bit and a 16-bit accumulator instance share
// stimulus; expected results are queued at job start and checked at out_valid.
module tb_pe_vec_mac;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] len;
  logic signed [31:0] bias;
  logic        in_valid;
  logic [31:0] ifmap;
  logic [31:0] weight;
  logic        out_ready;

  logic        busy, in_ready, out_valid, ovf;
  logic signed [31:0] opsum;
  logic        busy16, in_ready16, out_valid16, ovf16;
  logic signed [15:0] opsum16;

  int checks = 0;
  int errors = 0;
  int nacc = 0;
  int nrdy = 0;
  int nov  = 0;

  typedef struct {
    longint op;
    bit     ov;
    longint op16;
    bit     ov16;
  } exp_t;

  exp_t sbq[$];

  pe_vec_mac #(.LANES(4), .ACC_W(32), .ZP(128), .LEN_W(16)) u_dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .bias(bias), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .ifmap(ifmap), .weight(weight),
    .out_valid(out_valid), .out_ready(out_ready), .opsum(opsum), .ovf(ovf)
  );

  pe_vec_mac #(.LANES(4), .ACC_W(16), .ZP(128), .LEN_W(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(start), .len(len), .bias(bias[15:0]), .busy(busy16),
    .in_valid(in_valid), .in_ready(in_ready16), .ifmap(ifmap), .weight(weight),
    .out_valid(out_valid16), .out_ready(out_ready), .opsum(opsum16), .ovf(ovf16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event counters for accepted beats, ready cycles and valid cycles.
  always @(posedge clk) begin
    if (in_valid && in_ready) nacc <= nacc + 1;
    if (in_ready)             nrdy <= nrdy + 1;
    if (out_valid)            nov  <= nov + 1;
  end

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic longint dot(input logic [31:0] ifm, input logic [31:0] wt);
    longint s = 0;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] a;
      logic signed [7:0] b;
      a = ifm[i*8 +: 8];
      b = wt[i*8 +: 8];
      s += (longint'(a) - 128) * longint'(b);
    end
    return s;
  endfunction

  // Saturating accumulate model: returns clamped value and flags clamping.
  function automatic longint satw(input longint v, input int w, output bit hit);
    longint mx = (longint'(1) <<< (w - 1)) - 1;
    longint mn = -(longint'(1) <<< (w - 1));
    hit = 1'b0;
    if (v > mx) begin hit = 1'b1; return mx; end
    if (v < mn) begin hit = 1'b1; return mn; end
    return v;
  endfunction

  task automatic do_start(input int n, input longint b, input logic [31:0] ifm,
                          input logic [31:0] wt, input bit push);
    exp_t e;
    logic signed [15:0] b16;
    bit h;
    longint d;
    d = dot(ifm, wt);
    b16 = b[15:0];
    e.op = b; e.ov = 0;
    e.op16 = longint'(b16); e.ov16 = 0;
    for (int k = 0; k < n; k++) begin
      e.op = satw(e.op + d, 32, h);
      if (h) e.ov = 1;
      e.op16 = satw(e.op16 + d, 16, h);
      if (h) e.ov16 = 1;
    end
    if (push) sbq.push_back(e);
    @(negedge clk);
    start = 1'b1; len = 16'(n); bias = 32'(b);
    ifmap = ifm; weight = wt;
    @(negedge clk);
    start = 1'b0; len = 16'hBEEF; bias = 32'sd999;
  endtask

  // Offers beats (optionally every other cycle) until n have been accepted.
  task automatic feed(input int n, input bit gap, input logic [31:0] ifm, input logic [31:0] wt);
    int got = 0;
    int guard = 0;
    bit tog = 1'b1;
    while (got < n && guard < 100) begin
      in_valid = gap ? tog : 1'b1;
      ifmap = ifm; weight = wt;
      if (in_valid && in_ready) got++;
      tog = !tog;
      guard++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (got < n) chk("feed_timeout", got, n);
  endtask

  // Called half a cycle after the last accepting edge (or the len=0 start edge).
  task automatic collect(input string tag, input bit hold);
    exp_t e;
    chk({tag, "_ov_t0"}, out_valid, 0);
    @(negedge clk);
    chk({tag, "_ov_t1"}, out_valid, 0);
    @(negedge clk);
    chk({tag, "_ov_t2"}, out_valid, 1);
    if (sbq.size() == 0) begin
      chk({tag, "_sb_empty"}, sbq.size(), 1);
    end else begin
      e = sbq.pop_front();
      chk({tag, "_opsum"}, opsum, e.op);
      chk({tag, "_ovf"}, ovf, e.ov);
      chk({tag, "_opsum16"}, opsum16, e.op16);
      chk({tag, "_ovf16"}, ovf16, e.ov16);
    end
    if (!hold) begin
      @(negedge clk);
      chk({tag, "_ov_drop"}, out_valid, 0);
      chk({tag, "_idle"}, busy, 0);
    end
  endtask

  initial begin
    int snap;
    logic signed [31:0] held;
    rst = 1'b1; start = 1'b0; len = '0; bias = '0;
    in_valid = 1'b0; ifmap = '0; weight = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_opsum", opsum, 0);
    chk("rst_ovf", ovf, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single beat: 10 + 4*(130-128)*3 = 34.
    do_start(1, 10, {4{8'd130}}, {4{8'd3}}, 1);
    feed(1, 0, {4{8'd130}}, {4{8'd3}});
    collect("len1", 0);

    // Zero-length job returns the bias and never raises in_ready.
    snap = nrdy;
    do_start(0, -5, {4{8'd200}}, {4{8'd7}}, 1);
    in_valid = 1'b1;
    collect("len0", 0);
    in_valid = 1'b0;
    chk("len0_no_ready", nrdy - snap, 0);

    // Gapped input: 3 beats of 4*(-128*127) = -195072.
    snap = nacc;
    do_start(3, 0, {4{8'd0}}, {4{8'd127}}, 1);
    feed(3, 1, {4{8'd0}}, {4{8'd127}});
    collect("gap3", 0);
    chk("gap3_beats", nacc - snap, 3);

    // 16-bit instance saturates high; 32-bit instance holds 97283.
    do_start(1, 32767, {4{8'd255}}, {4{8'd127}}, 1);
    feed(1, 0, {4{8'd255}}, {4{8'd127}});
    collect("sat", 0);
    do_start(1, 1, {4{8'd129}}, {4{8'd1}}, 1);
    feed(1, 0, {4{8'd129}}, {4{8'd1}});
    collect("sat_clear", 0);

    // Backpressure: output held, start ignored, including on the handshake edge.
    out_ready = 1'b0;
    do_start(1, 7, {4{8'd128}}, {4{8'd5}}, 1);
    feed(1, 0, {4{8'd128}}, {4{8'd5}});
    collect("hold", 1);
    held = opsum;
    for (int c = 0; c < 5; c++) begin
      start = 1'b1; len = 16'd2; bias = 32'sd55;
      @(negedge clk);
      chk("hold_opsum", opsum, held);
      chk("hold_valid", out_valid, 1);
      chk("hold_busy", busy, 1);
    end
    out_ready = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("hs_valid_drop", out_valid, 0);
    chk("hs_idle", busy, 0);
    @(negedge clk);
    chk("hs_start_ignored", busy, 0);

    // Reset mid-job discards it; then a clean job: 100 + 2*4*(72*-2) = -1052.
    snap = nov;
    do_start(4, 3, {4{8'd140}}, {4{8'd9}}, 0);
    feed(2, 0, {4{8'd140}}, {4{8'd9}});
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_opsum", opsum, 0);
    chk("mid_rst_ovf", ovf, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("mid_rst_no_out", nov - snap, 0);
    do_start(2, 100, {4{8'd200}}, {4{8'hFE}}, 1);
    feed(2, 0, {4{8'd200}}, {4{8'hFE}});
    collect("post_rst", 0);

    chk("sb_drained", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
